aim_dispatch_scheduler: RTL
===========================

// Module: aim_dispatch_scheduler
// PURPOSE
//  Buffers the incoming AIM instruction stream and issues each instruction, in order, to the AI or GFX unit.
//  Classifies each instruction by its type field instr[31:28]: 4'b0001 = AI, 4'b0010 = GFX, any other value = illegal.
//  Limits the number of in-flight instructions per unit using completion credits.
//  Sits between fetch and the per-unit instruction decoders. The full 32-bit word is forwarded unchanged.
// PARAMETERS
//  FIFO_DEPTH   4   instruction buffer entries; power of 2, >= 2
//  MAX_OUT_AI   2   max AI instructions issued but not yet completed (1..15)
//  MAX_OUT_GFX  2   max GFX instructions issued but not yet completed (1..15)
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  in_valid       in   1   instruction offered
//  in_ready       out  1   buffer can accept
//  in_instr       in   32  instruction word
//  ai_valid       out  1   AI issue request
//  ai_ready       in   1   AI unit accepts
//  ai_instr       out  32  word issued to AI unit
//  ai_done        in   1   one-cycle pulse: one AI instruction completed
//  gfx_valid      out  1   GFX issue request
//  gfx_ready      in   1   GFX unit accepts
//  gfx_instr      out  32  word issued to GFX unit
//  gfx_done       in   1   one-cycle pulse: one GFX instruction completed
//  flush          in   1   discard all buffered (not yet issued) entries
//  illegal_pulse  out  1   one-cycle flag: an illegal word was dropped
//  illegal_instr  out  32  last dropped illegal word
//  fifo_level     out  $clog2(FIFO_DEPTH)+1   buffered entry count
//  idle           out  1   buffer empty and both in-flight counts are zero
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - FIFO emptied; ai_cnt and gfx_cnt = 0.
//   - illegal_pulse = 0, illegal_instr = 0, fifo_level = 0.
//   - Outputs while rst is high: in_ready = 0, ai_valid = gfx_valid = 0.
//   - idle = 1 from the first cycle after reset.
//   - Reset mid-operation discards buffered words and in-flight counts; done pulses for instructions issued before reset are not expected and are ignored.
//  Push:
//   - Fires on in_valid & in_ready. in_ready = !rst & (fifo_level != FIFO_DEPTH).
//   - A pop in the same cycle does not free space for a push (no bypass when full).
//  Head:
//   - Oldest entry. A pushed word becomes the head one cycle later at the earliest (1-cycle latency from push to valid).
//  Issue (in order; the head blocks everything behind it):
//   - ai_valid  = head present & type==0001 & ai_cnt  < MAX_OUT_AI  & !flush.
//   - gfx_valid = head present & type==0010 & gfx_cnt < MAX_OUT_GFX & !flush.
//   - ai_instr / gfx_instr = head word.
//   - All of these are driven from registers only; no combinational path from in_* or *_ready.
//   - Once valid is asserted, the word is held stable until ready (valid may drop only because of flush or rst).
//   - Pop on valid & ready.
//  Illegal head (type not 0001 and not 0010):
//   - Popped in the cycle it becomes head (unless flush is asserted).
//   - Next cycle: illegal_pulse = 1 for exactly one cycle, and illegal_instr = that word (held until the next illegal word).
//  Credits:
//   - ai_cnt next = ai_cnt + (ai issue fire) - ai_done. Issue and done in the same cycle leave the count unchanged.
//   - ai_done while ai_cnt==0 is ignored (count stays 0).
//   - A credit freed by done is usable from the next cycle.
//   - gfx_cnt behaves identically with gfx issue fire and gfx_done.
//  Flush:
//   - Blocks issue and push in its cycle (in_ready = 0).
//   - Empties the FIFO at the edge; fifo_level = 0 next cycle.
//   - ai_cnt, gfx_cnt and illegal_instr are unaffected.
//  Pointers:
//   - Read and write pointers wrap modulo FIFO_DEPTH.
//   - Full/empty are distinguished by fifo_level, never by pointer equality alone.
// TESTING
//  T1 reset:
//   - rst=1 for 2 cycles, then 0
//   - -> in_ready=1, ai_valid=gfx_valid=0, fifo_level=0, idle=1.
//  T2 single AI issue:
//   - push 0x130C_0405 with ai_ready=1
//   - -> ai_valid=1, ai_instr=0x130C_0405 on the next cycle; idle=0.
//   - ai_done pulse -> idle=1 on the following cycle.
//  T3 credit limit:
//   - push three AI words, ai_ready=1, no done
//   - -> two issue, the third waits with ai_valid=0.
//   - ai_done pulse -> the third issues one cycle later.
//  T4 in-order block:
//   - AI word then GFX 0x2100_0000, ai_ready=0, gfx_ready=1
//   - -> gfx_valid stays 0 until the AI word issues.
//  T5 illegal:
//   - push 0x3000_0000
//   - -> never appears on either issue port; illegal_pulse=1 for one cycle; illegal_instr=0x3000_0000.
//  T6 full and flush:
//   - 4 AI pushes with ai_ready=0 -> fifo_level=4, in_ready=0, 5th word not taken.
//   - flush=1 for one cycle -> fifo_level=0, in_ready=1; ai_cnt unchanged.

Source files
------------

// File: rtl/aim_dispatch_scheduler.sv
// Generic circular buffer with flush; level counter distinguishes full from empty.
// Latency: a pushed word is visible at head_dat one cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; no bypass.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    input  logic          flush,
    output logic [W-1:0]  head_dat,
    output logic [LW-1:0] level
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop_vld})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// In-order dispatcher: buffers AIM words and issues them to the AI or GFX unit under credits.
// Latency: one cycle from push to issue-valid; illegal words are reported the cycle after drop.
// Backpressure: in_ready drops when full, on flush or reset; the head blocks everything behind it.
module aim_dispatch_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_OUT_AI  = 2,
    parameter int MAX_OUT_GFX = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    output logic                          ai_valid,
    input  logic                          ai_ready,
    output logic [31:0]                   ai_instr,
    input  logic                          ai_done,
    output logic                          gfx_valid,
    input  logic                          gfx_ready,
    output logic [31:0]                   gfx_instr,
    input  logic                          gfx_done,
    input  logic                          flush,
    output logic                          illegal_pulse,
    output logic [31:0]                   illegal_instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [3:0]    AI_MAX   = 4'(MAX_OUT_AI);
    localparam logic [3:0]    GFX_MAX  = 4'(MAX_OUT_GFX);

    localparam logic [3:0] TYPE_AI  = 4'b0001;
    localparam logic [3:0] TYPE_GFX = 4'b0010;

    logic [31:0]   head;
    logic [LW-1:0] level;
    logic          head_vld;
    logic          is_ai;
    logic          is_gfx;
    logic          is_ill;
    logic          push;
    logic          pop;
    logic          ai_fire;
    logic          gfx_fire;
    logic          ill_pop;
    logic [3:0]    ai_cnt;
    logic [3:0]    gfx_cnt;
    logic [3:0]    ai_cnt_nxt;
    logic [3:0]    gfx_cnt_nxt;

    sync_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (in_instr),
        .pop_vld  (pop),
        .flush    (flush),
        .head_dat (head),
        .level    (level)
    );

    assign head_vld = (level != '0);
    assign is_ai    = (head[31:28] == TYPE_AI);
    assign is_gfx   = (head[31:28] == TYPE_GFX);
    assign is_ill   = !is_ai && !is_gfx;

    // Issue qualifiers depend only on buffered state, counters, flush and reset.
    assign in_ready  = !rst && (level != FULL_LVL) && !flush;
    assign ai_valid  = !rst && head_vld && is_ai  && (ai_cnt  < AI_MAX)  && !flush;
    assign gfx_valid = !rst && head_vld && is_gfx && (gfx_cnt < GFX_MAX) && !flush;
    assign ai_instr  = head;
    assign gfx_instr = head;

    assign push     = in_valid && in_ready;
    assign ai_fire  = ai_valid && ai_ready;
    assign gfx_fire = gfx_valid && gfx_ready;
    assign ill_pop  = !rst && head_vld && is_ill && !flush;
    assign pop      = ai_fire || gfx_fire || ill_pop;

    // A done pulse with nothing in flight is dropped, even if an issue fires alongside.
    function automatic logic [3:0] credit_next(input logic [3:0] cnt,
                                               input logic       fire,
                                               input logic       done);
        logic dec;
        dec = done && (cnt != 4'd0);
        if (fire && !dec) begin
            credit_next = cnt + 4'd1;
        end else if (!fire && dec) begin
            credit_next = cnt - 4'd1;
        end else begin
            credit_next = cnt;
        end
    endfunction

    assign ai_cnt_nxt  = credit_next(ai_cnt, ai_fire, ai_done);
    assign gfx_cnt_nxt = credit_next(gfx_cnt, gfx_fire, gfx_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            ai_cnt        <= 4'd0;
            gfx_cnt       <= 4'd0;
            illegal_pulse <= 1'b0;
            illegal_instr <= 32'd0;
        end else begin
            ai_cnt        <= ai_cnt_nxt;
            gfx_cnt       <= gfx_cnt_nxt;
            illegal_pulse <= ill_pop;
            if (ill_pop) begin
                illegal_instr <= head;
            end
        end
    end

    assign fifo_level = level;
    assign idle       = !head_vld && (ai_cnt == 4'd0) && (gfx_cnt == 4'd0);
endmodule
